// File: rtl/player_input_hub.sv
// rtl/player_input_hub.sv - per-player cursor/button pipeline, click event capture,
// round-robin arbitration and first-word-fall-through event queue.
module player_input_hub #(
  parameter int NUM_PLAYERS   = 2,
  parameter int CANVAS_WIDTH  = 360,
  parameter int CANVAS_HEIGHT = 720,
  parameter int SYNC_STAGES   = 3,
  parameter int FIFO_DEPTH    = 8,
  localparam int XW = $clog2(CANVAS_WIDTH),
  localparam int YW = $clog2(CANVAS_HEIGHT),
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_PLAYERS*XW-1:0] mouse_x_in,
  input  logic [NUM_PLAYERS*YW-1:0] mouse_y_in,
  input  logic [NUM_PLAYERS-1:0]    click_in,
  input  logic                      enable_in,
  output logic [NUM_PLAYERS*XW-1:0] mouse_x_out,
  output logic [NUM_PLAYERS*YW-1:0] mouse_y_out,
  output logic [NUM_PLAYERS-1:0]    click_out,
  output logic                      event_valid_out,
  input  logic                      event_ready_in,
  output logic [PW-1:0]             event_player_out,
  output logic [XW-1:0]             event_x_out,
  output logic [YW-1:0]             event_y_out,
  output logic                      overflow_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XW-1:0] X_MAX = XW'(CANVAS_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(CANVAS_HEIGHT - 1);

  logic [NUM_PLAYERS*XW-1:0] x_pipe [SYNC_STAGES];
  logic [NUM_PLAYERS*YW-1:0] y_pipe [SYNC_STAGES];
  logic [NUM_PLAYERS-1:0]    c_pipe [SYNC_STAGES];
  logic [NUM_PLAYERS*XW-1:0] x_pre;
  logic [NUM_PLAYERS*XW-1:0] x_lim;
  logic [NUM_PLAYERS*YW-1:0] y_pre;
  logic [NUM_PLAYERS*YW-1:0] y_lim;

  // The clamp sits in front of the final stage, so its input is stage S-2 (or the port).
  generate
    if (SYNC_STAGES > 1) begin : g_pre_multi
      assign x_pre = x_pipe[SYNC_STAGES-2];
      assign y_pre = y_pipe[SYNC_STAGES-2];
    end else begin : g_pre_single
      assign x_pre = mouse_x_in;
      assign y_pre = mouse_y_in;
    end
  endgenerate

  always_comb begin
    x_lim = x_pre;
    y_lim = y_pre;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (x_pre[p*XW +: XW] > X_MAX) x_lim[p*XW +: XW] = X_MAX;
      if (y_pre[p*YW +: YW] > Y_MAX) y_lim[p*YW +: YW] = Y_MAX;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
        c_pipe[i] <= '0;
      end
    end else begin
      x_pipe[0] <= mouse_x_in;
      y_pipe[0] <= mouse_y_in;
      c_pipe[0] <= click_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        x_pipe[i] <= x_pipe[i-1];
        y_pipe[i] <= y_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
      end
      x_pipe[SYNC_STAGES-1] <= x_lim;
      y_pipe[SYNC_STAGES-1] <= y_lim;
    end
  end

  assign mouse_x_out = x_pipe[SYNC_STAGES-1];
  assign mouse_y_out = y_pipe[SYNC_STAGES-1];
  assign click_out   = c_pipe[SYNC_STAGES-1];

  logic [NUM_PLAYERS-1:0] click_prev;
  logic [NUM_PLAYERS-1:0] rise;

  always_ff @(posedge clk_in) begin
    if (rst_in) click_prev <= '0;
    else        click_prev <= click_out;
  end

  // click_prev tracks regardless of enable, so re-enabling during a held press fires nothing.
  assign rise = click_out & ~click_prev & {NUM_PLAYERS{enable_in}};

  logic [NUM_PLAYERS-1:0] slot_flag;
  logic [XW-1:0]          slot_x [NUM_PLAYERS];
  logic [YW-1:0]          slot_y [NUM_PLAYERS];
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          rr_next;
  logic [PW-1:0]          grant_idx;
  logic                   grant_any;
  logic [NUM_PLAYERS-1:0] grant;
  logic [CW-1:0]          count;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   pop;
  logic                   push_ok;

  assign pop     = event_valid_out & event_ready_in;
  assign push_ok = (count < CW'(FIFO_DEPTH)) || pop;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (!grant_any && push_ok && slot_flag[(int'(rr_ptr) + k) % NUM_PLAYERS]) begin
        grant_any = 1'b1;
        grant_idx = PW'((int'(rr_ptr) + k) % NUM_PLAYERS);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      grant[p] = grant_any && (grant_idx == PW'(p));
    end
  end

  assign rr_next = PW'((int'(grant_idx) + 1) % NUM_PLAYERS);

  always_ff @(posedge clk_in) begin
    if (rst_in)         rr_ptr <= '0;
    else if (grant_any) rr_ptr <= rr_next;
  end

  // A slot being granted this cycle frees up in time to take the new event.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_flag    <= '0;
      overflow_out <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        slot_x[p] <= '0;
        slot_y[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (rise[p]) begin
          if (slot_flag[p] && !grant[p]) begin
            overflow_out <= 1'b1;
          end else begin
            slot_flag[p] <= 1'b1;
            slot_x[p]    <= mouse_x_out[p*XW +: XW];
            slot_y[p]    <= mouse_y_out[p*YW +: YW];
          end
        end else if (grant[p]) begin
          slot_flag[p] <= 1'b0;
        end
      end
    end
  end

  logic [PW-1:0] mem_p [FIFO_DEPTH];
  logic [XW-1:0] mem_x [FIFO_DEPTH];
  logic [YW-1:0] mem_y [FIFO_DEPTH];

  always_ff @(posedge clk_in) begin
    if (grant_any) begin
      mem_p[wr_ptr] <= grant_idx;
      mem_x[wr_ptr] <= slot_x[grant_idx];
      mem_y[wr_ptr] <= slot_y[grant_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant_any) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({grant_any, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign event_valid_out  = (count != '0);
  assign event_player_out = event_valid_out ? mem_p[rd_ptr] : '0;
  assign event_x_out      = event_valid_out ? mem_x[rd_ptr] : '0;
  assign event_y_out      = event_valid_out ? mem_y[rd_ptr] : '0;

endmodule

// File: tb/tb_player_input_hub.sv
// tb/tb_player_input_hub.sv - directed self-checking bench for player_input_hub.
module tb_player_input_hub;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] mouse_x_in;
  logic [19:0] mouse_y_in;
  logic [1:0]  click_in;
  logic        enable_in;
  logic [17:0] mouse_x_out;
  logic [19:0] mouse_y_out;
  logic [1:0]  click_out;
  logic        event_valid_out;
  logic        event_ready_in;
  logic [0:0]  event_player_out;
  logic [8:0]  event_x_out;
  logic [9:0]  event_y_out;
  logic        overflow_out;

  int checks = 0;
  int errors = 0;

  player_input_hub dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .mouse_x_in      (mouse_x_in),
    .mouse_y_in      (mouse_y_in),
    .click_in        (click_in),
    .enable_in       (enable_in),
    .mouse_x_out     (mouse_x_out),
    .mouse_y_out     (mouse_y_out),
    .click_out       (click_out),
    .event_valid_out (event_valid_out),
    .event_ready_in  (event_ready_in),
    .event_player_out(event_player_out),
    .event_x_out     (event_x_out),
    .event_y_out     (event_y_out),
    .overflow_out    (overflow_out)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pos(input int p, input int x, input int y);
    mouse_x_in[p*9 +: 9]  = 9'(x);
    mouse_y_in[p*10 +: 10] = 10'(y);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mouse_x_in = '0; mouse_y_in = '0; click_in = '0;
    enable_in = 1'b1; event_ready_in = 1'b0;
    step(2);
    checks++; if (mouse_x_out !== 18'd0) begin errors++; $display("FAIL reset_x got %0h want 0", mouse_x_out); end
    checks++; if (mouse_y_out !== 20'd0) begin errors++; $display("FAIL reset_y got %0h want 0", mouse_y_out); end
    checks++; if (click_out !== 2'b00) begin errors++; $display("FAIL reset_click got %b want 00", click_out); end
    checks++; if (event_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", event_valid_out); end
    checks++; if ({event_player_out, event_x_out, event_y_out} !== 20'd0) begin errors++; $display("FAIL reset_head got %0h want 0", {event_player_out, event_x_out, event_y_out}); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow_out); end
    rst = 1'b0;
    set_pos(0, 100, 200);
    step(2);
    checks++; if (mouse_x_out[8:0] !== 9'd0) begin errors++; $display("FAIL pipe_early got %0d want 0", mouse_x_out[8:0]); end
    step(1);
    checks++; if (mouse_x_out[8:0] !== 9'd100) begin errors++; $display("FAIL pipe_x got %0d want 100", mouse_x_out[8:0]); end
    checks++; if (mouse_y_out[9:0] !== 10'd200) begin errors++; $display("FAIL pipe_y got %0d want 200", mouse_y_out[9:0]); end
  endtask

  task automatic test_clamp_and_click;
    int vcount;
    set_pos(1, 400, 900);
    set_pos(0, 359, 719);
    event_ready_in = 1'b1;
    step(3);
    checks++; if (mouse_x_out[17:9] !== 9'd359) begin errors++; $display("FAIL clamp_x got %0d want 359", mouse_x_out[17:9]); end
    checks++; if (mouse_y_out[19:10] !== 10'd719) begin errors++; $display("FAIL clamp_y got %0d want 719", mouse_y_out[19:10]); end
    checks++; if (mouse_x_out[8:0] !== 9'd359 || mouse_y_out[9:0] !== 10'd719) begin errors++; $display("FAIL clamp_edge got %0d,%0d want 359,719", mouse_x_out[8:0], mouse_y_out[9:0]); end
    click_in[1] = 1'b1;
    vcount = 0;
    for (int c = 1; c <= 55; c++) begin
      step(1);
      if (c == 4) begin
        checks++; if (event_valid_out !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", event_valid_out); end
      end
      if (c == 5) begin
        checks++; if (event_valid_out !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", event_valid_out); end
        checks++; if ({event_player_out, event_x_out, event_y_out} !== {1'b1, 9'd359, 10'd719}) begin errors++; $display("FAIL click_payload got %0d,%0d,%0d want 1,359,719", event_player_out, event_x_out, event_y_out); end
      end
      if (event_valid_out === 1'b1) vcount++;
    end
    checks++; if (vcount !== 1) begin errors++; $display("FAIL held_single got %0d valid cycles want 1", vcount); end
    click_in[1] = 1'b0;
    step(4);
  endtask

  task automatic test_round_robin;
    event_ready_in = 1'b1;
    set_pos(0, 20, 30);
    set_pos(1, 40, 50);
    step(4);
    click_in = 2'b11;
    step(5);
    checks++; if ({event_valid_out, event_player_out, event_x_out} !== {1'b1, 1'b0, 9'd20}) begin errors++; $display("FAIL rr_first got v%b p%0d x%0d want v1 p0 x20", event_valid_out, event_player_out, event_x_out); end
    step(1);
    checks++; if ({event_valid_out, event_player_out, event_x_out} !== {1'b1, 1'b1, 9'd40}) begin errors++; $display("FAIL rr_second got v%b p%0d x%0d want v1 p1 x40", event_valid_out, event_player_out, event_x_out); end
    step(1);
    checks++; if (event_valid_out !== 1'b0) begin errors++; $display("FAIL rr_drained got %b want 0", event_valid_out); end
    click_in = 2'b00;
    step(4);
    // a lone player-0 event moves the pointer to player 1
    click_in = 2'b01;
    step(6);
    click_in = 2'b00;
    step(4);
    click_in = 2'b11;
    step(5);
    checks++; if ({event_valid_out, event_player_out, event_y_out} !== {1'b1, 1'b1, 10'd50}) begin errors++; $display("FAIL rr_rot_first got v%b p%0d y%0d want v1 p1 y50", event_valid_out, event_player_out, event_y_out); end
    step(1);
    checks++; if ({event_valid_out, event_player_out, event_y_out} !== {1'b1, 1'b0, 10'd30}) begin errors++; $display("FAIL rr_rot_second got v%b p%0d y%0d want v1 p0 y30", event_valid_out, event_player_out, event_y_out); end
    click_in = 2'b00;
    step(5);
  endtask

  task automatic test_fifo_full_and_drain;
    event_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_pos(0, 10 + i, 50);
      click_in[0] = 1'b1;
      step(2);
      click_in[0] = 1'b0;
      step(2);
      if (i == 8) begin
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_before_drop got %b want 0", overflow_out); end
      end
    end
    step(6);
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_out); end
    for (int s = 0; s < 3; s++) begin
      checks++; if ({event_valid_out, event_player_out, event_x_out, event_y_out} !== {1'b1, 1'b0, 9'd10, 10'd50}) begin errors++; $display("FAIL head_stable got v%b p%0d x%0d y%0d want v1 p0 x10 y50", event_valid_out, event_player_out, event_x_out, event_y_out); end
      step(1);
    end
    event_ready_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checks++; if ({event_valid_out, event_player_out, event_x_out} !== {1'b1, 1'b0, 9'(10 + k)}) begin errors++; $display("FAIL drain_%0d got v%b p%0d x%0d want v1 p0 x%0d", k, event_valid_out, event_player_out, event_x_out, 10 + k); end
      step(1);
    end
    checks++; if (event_valid_out !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", event_valid_out); end
  endtask

  task automatic test_enable;
    int vcount;
    event_ready_in = 1'b1;
    enable_in = 1'b0;
    click_in[0] = 1'b1;
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (event_valid_out === 1'b1) vcount++;
    end
    checks++; if (click_out[0] !== 1'b1) begin errors++; $display("FAIL disabled_pipe got %b want 1", click_out[0]); end
    enable_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (event_valid_out === 1'b1) vcount++;
    end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL disabled_events got %0d want 0", vcount); end
    click_in[0] = 1'b0;
    step(4);
  endtask

  task automatic test_reset_mid_burst;
    event_ready_in = 1'b0;
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_out); end
    for (int i = 0; i < 5; i++) begin
      set_pos(0, 70 + i, 60);
      click_in[0] = 1'b1;
      step(2);
      click_in[0] = 1'b0;
      step(2);
    end
    step(6);
    checks++; if ({event_valid_out, event_x_out} !== {1'b1, 9'd70}) begin errors++; $display("FAIL burst_queued got v%b x%0d want v1 x70", event_valid_out, event_x_out); end
    set_pos(0, 123, 77);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (event_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", event_valid_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow_out); end
    checks++; if (mouse_x_out !== 18'd0) begin errors++; $display("FAIL rst_pipe got %0h want 0", mouse_x_out); end
    event_ready_in = 1'b1;
    set_pos(0, 5, 6);
    set_pos(1, 7, 8);
    step(4);
    click_in = 2'b11;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      if (c == 4) begin
        checks++; if (event_valid_out !== 1'b0) begin errors++; $display("FAIL post_rst_early got %b want 0", event_valid_out); end
      end
      if (c == 5) begin
        checks++; if ({event_valid_out, event_player_out, event_x_out, event_y_out} !== {1'b1, 1'b0, 9'd5, 10'd6}) begin errors++; $display("FAIL post_rst_first got v%b p%0d x%0d y%0d want v1 p0 x5 y6", event_valid_out, event_player_out, event_x_out, event_y_out); end
      end
      if (c == 6) begin
        checks++; if ({event_valid_out, event_player_out, event_x_out, event_y_out} !== {1'b1, 1'b1, 9'd7, 10'd8}) begin errors++; $display("FAIL post_rst_second got v%b p%0d x%0d y%0d want v1 p1 x7 y8", event_valid_out, event_player_out, event_x_out, event_y_out); end
      end
      if (c == 7) begin
        checks++; if (event_valid_out !== 1'b0) begin errors++; $display("FAIL post_rst_empty got %b want 0", event_valid_out); end
      end
    end
    click_in = 2'b00;
    step(4);
  endtask

  initial begin
    test_reset;
    test_clamp_and_click;
    test_round_robin;
    test_fifo_full_and_drain;
    test_enable;
    test_reset_mid_burst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
